operand_buffer: RTL and testbench
=================================

Name: operand_buffer

Overview:
Sits directly downstream of the DMA opcode decoder. It captures weight and input bytes addressed by the decoder into two small register banks. On a start request it sequences them into the systolic array: first a row-by-row weight preload, then a row-skewed input stream. It reports busy and done back to the controller.

Parameters:
N, 2, systolic array dimension (N x N PEs); each bank holds N*N bytes.
DW, 8, data byte width.
AW, 4, DMA address width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (asserted at 0).
fetch_w  in  1  write data_in to weight bank at dma_address.
fetch_inp  in  1  write data_in to input bank at dma_address.
start  in  1  level request; a rising edge launches a sequence.
dma_address  in  AW  bank index, row*N+col.
data_in  in  DW  byte to store.
w_out  out  N*DW  weight row; lane c at bits [DW*c+DW-1 : DW*c].
load_weight  out  1  w_out valid for the array's weight latch.
a_out  out  N*DW  input lanes, one per array row, same lane packing.
a_valid  out  N  per-lane valid for a_out.
busy  out  1  sequence in progress.
done  out  1  one-cycle pulse after the last stream cycle.
err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (async, reset=0): both banks cleared to 0; state IDLE; all outputs 0; start_q=0.
- Writes: synchronous, only in IDLE.
  - fetch_w writes the weight bank; fetch_inp writes the input bank.
  - If both are asserted, fetch_w wins.
  - dma_address >= N*N: write is dropped.
  - A write during busy is dropped.
- Start detect: start_q registers start each cycle; trigger = start & ~start_q & (state==IDLE).
  - A trigger raised while busy is ignored; a held start cannot retrigger.
  - A write and a trigger in the same IDLE cycle: the write commits and is visible to the sequence.
- States:
  - IDLE -> LOAD_W on trigger.
  - LOAD_W: N cycles, k = 0..N-1; load_weight=1; w_out lane c = W[k*N+c]; goes to STREAM after k = N-1.
  - STREAM: 2N-1 cycles, t = 0..2N-2. For each lane r, let i = t-r:
    - if 0 <= i < N: a_out lane r = X[i*N+r] and a_valid[r]=1;
    - otherwise lane r = 0 and a_valid[r]=0.
    - Goes to DONE after t = 2N-2.
  - DONE: 1 cycle, done=1; then IDLE.
- All outputs are registered.
  - First load_weight cycle is the cycle after the edge that samples the trigger.
  - busy=1 in LOAD_W, STREAM and DONE, so busy spans 3N cycles.
- Outputs outside their state:
  - w_out = 0 and load_weight = 0 outside LOAD_W.
  - a_out = 0 and a_valid = 0 outside STREAM.
- Counters: k and t use clog2(2N) bits and are cleared on every state entry.
- Reset mid-sequence: immediately IDLE with outputs 0; banks cleared; no done pulse.

Optional Feature:
Macro OPBUF_ERR_FLAG_EN.
- Defined: err goes to 1 on any dropped write (out-of-range address, or write while busy). It stays 1 until reset or the next accepted trigger, which clears it on the trigger edge.
- Undefined: err is tied 0, with no error logic.

Decomposition:
- Package opbuf_pkg holds:
  - state enum {IDLE, LOAD_W, STREAM, DONE};
  - localparam DEPTH = N*N;
  - lane packing helper constants.
- Sub-module operand_bank (N*N x DW register file, async-reset clear, single write port, full parallel read) is instantiated twice, once for weights and once for inputs.
- The sequencer FSM lives in the top module.

Test Plan:
- Weight preload (N=2): fetch_w bytes 0x11, 0x22, 0x33, 0x44 at addresses 0..3; pulse start -> next cycle w_out=0x2211 with load_weight=1, then w_out=0x4433, then load_weight=0.
- Input skew: fetch_inp 1, 2, 3, 4 at addresses 0..3, then start ->
  - stream t0: a_out=0x0001, a_valid=01;
  - t1: a_out=0x0203, a_valid=11;
  - t2: a_out=0x0400, a_valid=10;
  - then done=1 for one cycle; busy high for exactly 6 cycles.
- Drops: fetch_w at address 5, and fetch_w during busy -> bank contents unchanged on the next sequence; err=1 with OPBUF_ERR_FLAG_EN, 0 without.
- Start held high for 10 cycles -> exactly one sequence and one done pulse; a new rising edge during busy is ignored.
- Reset asserted in STREAM cycle t1 -> all outputs 0 asynchronously; no done; the next sequence streams zeros from the cleared banks.
- fetch_w and fetch_inp asserted together at address 2 with data 0x7F -> only W[2]=0x7F; X[2] stays 0.

Source files
------------

// File: rtl/opbuf_pkg.sv
// Shared constants, sequencer state type and lane-packing helper for the operand buffer.
// Lane c of any N*DW output bus occupies bits [DW*c +: DW].
package opbuf_pkg;

  localparam int N      = 2;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int DEPTH  = N * N;
  localparam int CNT_W  = $clog2(2 * N);
  localparam int LANE_W = N * DW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int lane_lsb(input int lane);
    return lane * DW;
  endfunction

endpackage

// File: rtl/operand_bank.sv
// DEPTH x DW register file: async clear, one write port, every entry readable in parallel.
// Addresses outside 0..DEPTH-1 match no entry, so those writes are silently lost.
module operand_bank
  import opbuf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DW-1:0]         i_data,
  output logic [DEPTH*DW-1:0]   o_mem
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
    end else if (i_we) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (i_addr == AW'(e)) r_mem[e] <= i_data;
      end
    end
  end

  always_comb begin
    o_mem = '0;
    for (int e = 0; e < DEPTH; e++) o_mem[e*DW +: DW] = r_mem[e];
  end

endmodule

// File: rtl/operand_buffer.sv
// Captures weight/input bytes, then plays a weight preload followed by a row-skewed input stream.
// Optional sticky drop flag on err is built only when OPBUF_ERR_FLAG_EN is defined.
module operand_buffer
  import opbuf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_w,
  input  logic              fetch_inp,
  input  logic              start,
  input  logic [AW-1:0]     dma_address,
  input  logic [DW-1:0]     data_in,
  output logic [LANE_W-1:0] w_out,
  output logic              load_weight,
  output logic [LANE_W-1:0] a_out,
  output logic [N-1:0]      a_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            o_dbg_state
);

  // Output qualifiers: load_weight and a_valid[r] are plain valids with no ready;
  // the array must take w_out / a_out lane r in every cycle the matching valid is high.

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_start_q;
  logic [LANE_W-1:0]   r_w_out;
  logic                r_load_weight;
  logic [LANE_W-1:0]   r_a_out;
  logic [N-1:0]        r_a_valid;
  logic                r_busy;
  logic                r_done;

  logic                w_idle;
  logic                w_trigger;
  logic                w_w_we;
  logic                w_x_we;
  logic [DEPTH*DW-1:0] w_w_mem;
  logic [DEPTH*DW-1:0] w_x_mem;
  logic [DEPTH*DW-1:0] w_w_fwd;
  state_t              w_nxt_state;
  logic [CNT_W-1:0]    w_nxt_cnt;
  logic [LANE_W-1:0]   w_w_row;
  logic [LANE_W-1:0]   w_a_row;
  logic [N-1:0]        w_a_vld;

  assign w_idle    = (r_state == IDLE);
  assign w_trigger = start & ~r_start_q & w_idle;
  assign w_w_we    = fetch_w & w_idle;
  assign w_x_we    = fetch_inp & ~fetch_w & w_idle;

  operand_bank u_w_bank (
    .clk    (clk),
    .rst_n  (reset),
    .i_we   (w_w_we),
    .i_addr (dma_address),
    .i_data (data_in),
    .o_mem  (w_w_mem)
  );

  operand_bank u_x_bank (
    .clk    (clk),
    .rst_n  (reset),
    .i_we   (w_x_we),
    .i_addr (dma_address),
    .i_data (data_in),
    .o_mem  (w_x_mem)
  );

  // Row 0 is registered on the trigger edge, so a weight write in that same cycle is forwarded.
  always_comb begin
    w_w_fwd = w_w_mem;
    for (int e = 0; e < DEPTH; e++) begin
      if (w_w_we && (dma_address == AW'(e))) w_w_fwd[e*DW +: DW] = data_in;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + 1'b1;
    case (r_state)
      IDLE:    if (w_trigger) w_nxt_state = LOAD_W;
      LOAD_W:  if (r_cnt == CNT_W'(N - 1)) w_nxt_state = STREAM;
      STREAM:  if (r_cnt == CNT_W'(2 * N - 2)) w_nxt_state = DONE;
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
    if ((w_nxt_state != r_state) || (r_state == IDLE)) w_nxt_cnt = '0;
  end

  always_comb begin
    w_w_row = '0;
    if (w_nxt_state == LOAD_W) begin
      for (int k = 0; k < N; k++) begin
        for (int c = 0; c < N; c++) begin
          if (w_nxt_cnt == CNT_W'(k)) w_w_row[lane_lsb(c) +: DW] = w_w_fwd[(k*N + c)*DW +: DW];
        end
      end
    end
  end

  // Lane r carries input row i at stream step t = i + r.
  always_comb begin
    w_a_row = '0;
    w_a_vld = '0;
    if (w_nxt_state == STREAM) begin
      for (int r = 0; r < N; r++) begin
        for (int i = 0; i < N; i++) begin
          if (w_nxt_cnt == CNT_W'(i + r)) begin
            w_a_row[lane_lsb(r) +: DW] = w_x_mem[(i*N + r)*DW +: DW];
            w_a_vld[r]                 = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_start_q     <= 1'b0;
      r_w_out       <= '0;
      r_load_weight <= 1'b0;
      r_a_out       <= '0;
      r_a_valid     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_start_q     <= start;
      r_state       <= w_nxt_state;
      r_cnt         <= w_nxt_cnt;
      r_w_out       <= w_w_row;
      r_load_weight <= (w_nxt_state == LOAD_W);
      r_a_out       <= w_a_row;
      r_a_valid     <= w_a_vld;
      r_busy        <= (w_nxt_state != IDLE);
      r_done        <= (w_nxt_state == DONE);
    end
  end

  assign w_out       = r_w_out;
  assign load_weight = r_load_weight;
  assign a_out       = r_a_out;
  assign a_valid     = r_a_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

`ifdef OPBUF_ERR_FLAG_EN
  logic r_err;
  logic w_drop;

  assign w_drop = (fetch_w | fetch_inp) & (~w_idle | (dma_address >= AW'(DEPTH)));

  // A drop on the trigger edge itself keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_err <= 1'b0;
    else if (w_drop)    r_err <= 1'b1;
    else if (w_trigger) r_err <= 1'b0;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_operand_buffer.sv
// Scoreboard bench for operand_buffer: a bank/sequence model pushes expected per-cycle outputs,
// a negedge monitor pops and compares them. Honours OPBUF_ERR_FLAG_EN like the design.
module tb_operand_buffer;
  import opbuf_pkg::*;

  localparam int TN = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_w, fetch_inp, start;
  logic [3:0]  dma_address;
  logic [7:0]  data_in;
  logic [15:0] w_out, a_out;
  logic        load_weight, busy, done, err;
  logic [1:0]  a_valid;
  state_t      dbg_state;

  operand_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_w     (fetch_w),
    .fetch_inp   (fetch_inp),
    .start       (start),
    .dma_address (dma_address),
    .data_in     (data_in),
    .w_out       (w_out),
    .load_weight (load_weight),
    .a_out       (a_out),
    .a_valid     (a_valid),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model
  typedef struct packed {
    logic [15:0] w;
    logic        lw;
    logic [15:0] a;
    logic [1:0]  av;
    logic        dn;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] wm [TN*TN];
  logic [7:0] xm [TN*TN];
  int         m_busy_left = 0;
  bit         m_start_q   = 0;
  bit         m_err       = 0;
  int         n_seq = 0, n_aborted = 0, n_done = 0;
  int         n_checks = 0, n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int e = 0; e < TN*TN; e++) begin
      wm[e] = 8'h00;
      xm[e] = 8'h00;
    end
    m_busy_left = 0;
    m_start_q   = 0;
    m_err       = 0;
  endtask

  task automatic push_sequence();
    rec_t r;
    for (int k = 0; k < TN; k++) begin
      r = '0;
      for (int c = 0; c < TN; c++) r.w[c*8 +: 8] = wm[k*TN + c];
      r.lw = 1'b1;
      exp_q.push_back(r);
    end
    for (int t = 0; t <= 2*TN - 2; t++) begin
      r = '0;
      for (int rr = 0; rr < TN; rr++) begin
        int i;
        i = t - rr;
        if (i >= 0 && i < TN) begin
          r.a[rr*8 +: 8] = xm[i*TN + rr];
          r.av[rr]       = 1'b1;
        end
      end
      exp_q.push_back(r);
    end
    r = '0;
    r.dn = 1'b1;
    exp_q.push_back(r);
  endtask

  // Applied once per rising edge using the inputs that edge sampled.
  task automatic model_edge();
    bit idle, trig;
    idle = (m_busy_left == 0);
    trig = start && !m_start_q && idle;
`ifdef OPBUF_ERR_FLAG_EN
    if (trig) m_err = 0;
`endif
    if (fetch_w || fetch_inp) begin
      if (idle && dma_address < TN*TN) begin
        if (fetch_w) wm[dma_address] = data_in;
        else         xm[dma_address] = data_in;
      end else begin
`ifdef OPBUF_ERR_FLAG_EN
        m_err = 1;
`endif
      end
    end
    if (trig) begin
      push_sequence();
      n_seq++;
      m_busy_left = 3*TN;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end
    m_start_q = start;
  endtask

  // driver tasks
  task automatic step(input logic fw, input logic fi, input logic st,
                      input logic [3:0] addr, input logic [7:0] d);
    fetch_w     = fw;
    fetch_inp   = fi;
    start       = st;
    dma_address = addr;
    data_in     = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 8'h00);
  endtask

  task automatic mid_reset();
    #1 reset = 1'b0;
    #1 chk("async_reset_out", {w_out, load_weight, a_out, a_valid, busy, done, err}, '0);
    if (m_busy_left > 0) n_aborted++;
    exp_q.delete();
    model_clear();
    fetch_w = 0; fetch_inp = 0; start = 0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    rec_t e;
    if (reset === 1'b1) begin
      chk("busy", {63'd0, busy}, {63'd0, m_busy_left > 0});
      if (m_busy_left > 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL seq_extra: busy with empty expected queue at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("seq_out", {w_out, load_weight, a_out, a_valid, done}, e);
        end
      end else begin
        chk("idle_out", {w_out, load_weight, a_out, a_valid, done}, '0);
      end
      if (done === 1'b1) n_done++;
      chk("err", {63'd0, err}, {63'd0, m_err});
    end
  end

  // stimulus
  initial begin
    reset = 1'b0;
    fetch_w = 0; fetch_inp = 0; start = 0; dma_address = '0; data_in = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 chk("reset_out", {w_out, load_weight, a_out, a_valid, busy, done, err}, '0);
    reset = 1'b1;

    // weight preload and input skew
    step(1, 0, 0, 4'd0, 8'h11); step(1, 0, 0, 4'd1, 8'h22);
    step(1, 0, 0, 4'd2, 8'h33); step(1, 0, 0, 4'd3, 8'h44);
    step(0, 1, 0, 4'd0, 8'h01); step(0, 1, 0, 4'd1, 8'h02);
    step(0, 1, 0, 4'd2, 8'h03); step(0, 1, 0, 4'd3, 8'h04);
    step(0, 0, 1, 4'd0, 8'h00);
    idle_steps(8);

    // dropped writes: out of range, then during busy
    step(1, 0, 0, 4'd5, 8'hAA);
    step(0, 0, 1, 4'd0, 8'h00);
    step(1, 0, 0, 4'd0, 8'hBB);
    step(0, 1, 0, 4'd3, 8'hCC);
    idle_steps(6);
    step(0, 0, 1, 4'd0, 8'h00);
    idle_steps(8);

    // held start, then a fresh edge inside busy
    for (int i = 0; i < 10; i++) step(0, 0, 1, 4'd0, 8'h00);
    step(0, 0, 0, 4'd0, 8'h00);
    step(0, 0, 1, 4'd0, 8'h00);
    step(0, 0, 0, 4'd0, 8'h00);
    step(0, 0, 1, 4'd0, 8'h00);
    idle_steps(8);

    // reset during stream step t1
    step(0, 1, 0, 4'd1, 8'h5A);
    step(0, 0, 1, 4'd0, 8'h00);
    idle_steps(3);
    mid_reset();
    step(0, 0, 1, 4'd0, 8'h00);
    idle_steps(8);

    // simultaneous fetch: weight bank wins
    step(1, 1, 0, 4'd2, 8'h7F);
    step(0, 0, 1, 4'd0, 8'h00);
    idle_steps(8);

    // write in the trigger cycle is visible to the sequence
    step(1, 0, 1, 4'd1, 8'hE5);
    idle_steps(8);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           4'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end
    idle_steps(10);

    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", n_done, n_seq - n_aborted);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
